// File: rtl/muldiv_unit.sv
// muldiv_unit: MIPS multiply/divide unit owning HI/LO; single-edge multiply, restoring divide one bit per cycle.
// Optional MULDIV_ABORT_EN adds an abort input that squashes an in-flight divide without touching HI/LO.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
`ifdef MULDIV_ABORT_EN
    ,
    input  logic             abort
`endif
);
    typedef enum logic [1:0] {IDLE, DIV_RUN, DIV_FIX} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] rem, quo, dvs;
    logic [CNT_W-1:0] cnt;
    logic q_neg, r_neg, kill;
    logic accept, is_mul, is_div, sgn, a_neg, b_neg;
    logic [2*WIDTH-1:0] ext_a, ext_b, prod;
    logic [WIDTH:0] rem_sh, trial;

`ifdef MULDIV_ABORT_EN
    assign kill = abort & busy;
`else
    assign kill = 1'b0;
`endif

    assign accept = op_valid && state == IDLE;
    assign is_mul = op[2:1] == 2'b00;
    assign is_div = op[2:1] == 2'b01;
    assign sgn    = ~op[0];
    assign a_neg  = sgn & SrcA[WIDTH-1];
    assign b_neg  = sgn & SrcB[WIDTH-1];
    // Sign-extending to 2*WIDTH lets one unsigned multiplier serve both MULT and MULTU.
    assign ext_a  = {{WIDTH{a_neg}}, SrcA};
    assign ext_b  = {{WIDTH{b_neg}}, SrcB};
    assign prod   = ext_a * ext_b;
    assign rem_sh = {rem, quo[WIDTH-1]};
    assign trial  = rem_sh - {1'b0, dvs};

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else       state <= state_n;

    always_comb begin
        state_n = kill ? IDLE :
                  (accept && is_div && |SrcB) ? DIV_RUN :
                  (state == DIV_RUN && cnt == CNT_W'(WIDTH - 1)) ? DIV_FIX :
                  (state == DIV_FIX) ? IDLE : state;
    end

    always_comb begin
        busy = state != IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
            cnt   <= '0;
            rem   <= '0;
            quo   <= '0;
            dvs   <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                if (is_mul) begin
                    {hi, lo} <= prod;
                    done     <= 1'b1;
                end else if (op == 3'b100) begin
                    hi   <= SrcA;
                    done <= 1'b1;
                end else if (op == 3'b101) begin
                    lo   <= SrcA;
                    done <= 1'b1;
                end else if (is_div && SrcB == '0) begin
                    hi   <= SrcA;
                    lo   <= '1;
                    done <= 1'b1;
                end else if (is_div) begin
                    quo   <= a_neg ? -SrcA : SrcA;
                    dvs   <= b_neg ? -SrcB : SrcB;
                    q_neg <= a_neg ^ b_neg;
                    r_neg <= a_neg;
                    rem   <= '0;
                    cnt   <= '0;
                end
            end else if (state == DIV_RUN) begin
                rem <= trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
                cnt <= cnt + CNT_W'(1);
            end else if (state == DIV_FIX && !kill) begin
                lo   <= q_neg ? -quo : quo;
                hi   <= r_neg ? -rem : rem;
                done <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit at WIDTH=32.
module tb_muldiv_unit;
    logic        clk = 0, reset = 0, op_valid = 0;
    logic [2:0]  op = 3'b111;
    logic [31:0] SrcA = 0, SrcB = 0;
    logic        busy, done;
    logic [31:0] hi, lo;
`ifdef MULDIV_ABORT_EN
    logic        abort = 0;
`endif
    int tests = 0, fails = 0;

    muldiv_unit dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op(op),
        .SrcA(SrcA), .SrcB(SrcB), .busy(busy), .done(done), .hi(hi), .lo(lo)
`ifdef MULDIV_ABORT_EN
        , .abort(abort)
`endif
    );

    always #5 clk = ~clk;

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op_valid = 1; op = o; SrcA = a; SrcB = b;
        @(negedge clk);
        op_valid = 0; op = 3'b111;
    endtask

    task automatic test_reset;
        reset = 1;
        #12;
        tests++;
        if ({busy, done, hi, lo} !== 66'd0) begin
            fails++;
            $display("FAIL reset: busy=%b done=%b hi=%h lo=%h, need all 0", busy, done, hi, lo);
        end
        @(negedge clk);
        reset = 0;
    endtask

    task automatic test_mul;
        issue(3'b000, 32'hFFFFFFFF, 32'h2);
        tests++;
        if ({busy, done, hi, lo} !== {2'b01, 32'hFFFFFFFF, 32'hFFFFFFFE}) begin
            fails++;
            $display("FAIL mult: busy=%b done=%b hi=%h lo=%h, need 0 1 ffffffff fffffffe", busy, done, hi, lo);
        end
        issue(3'b001, 32'hFFFFFFFF, 32'h2);
        tests++;
        if ({busy, done, hi, lo} !== {2'b01, 32'h1, 32'hFFFFFFFE}) begin
            fails++;
            $display("FAIL multu: busy=%b done=%b hi=%h lo=%h, need 0 1 00000001 fffffffe", busy, done, hi, lo);
        end
        issue(3'b000, 32'd7, 32'hFFFFFFFD);
        tests++;
        if ({hi, lo} !== {32'hFFFFFFFF, 32'hFFFFFFEB}) begin
            fails++;
            $display("FAIL mult_7x-3: hi=%h lo=%h, need ffffffff ffffffeb", hi, lo);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL done_pulse: done=%b, need 0", done);
        end
    endtask

    task automatic run_div(input string name, input logic [2:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        int n = 0;
        issue(o, a, b);
        while (busy === 1'b1 && n < 100) begin
            n++;
            if (done !== 1'b0) begin
                fails++;
                $display("FAIL %s_early_done: done=1 at busy cycle %0d", name, n);
            end
            @(negedge clk);
        end
        tests++;
        if (n != 33) begin
            fails++;
            $display("FAIL %s_busy_len: busy cycles=%0d, need 33", name, n);
        end
        tests++;
        if ({done, hi, lo} !== {1'b1, eh, el}) begin
            fails++;
            $display("FAIL %s_result: done=%b hi=%h lo=%h, need 1 %h %h", name, done, hi, lo, eh, el);
        end
    endtask

    task automatic test_div;
        run_div("div_m7_2", 3'b010, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_div("divu_m7_2", 3'b011, 32'hFFFFFFF9, 32'd2, 32'h1, 32'h7FFFFFFC);
        run_div("div_ovf", 3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
        run_div("div_7_m2", 3'b010, 32'd7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD);
    endtask

    task automatic test_div_zero;
        issue(3'b010, 32'd5, 32'd0);
        tests++;
        if ({busy, done, hi, lo} !== {2'b01, 32'd5, 32'hFFFFFFFF}) begin
            fails++;
            $display("FAIL div_zero: busy=%b done=%b hi=%h lo=%h, need 0 1 00000005 ffffffff", busy, done, hi, lo);
        end
    endtask

    task automatic test_busy_ignore;
        int n = 0;
        issue(3'b010, 32'hFFFFFFF9, 32'd2);
        @(negedge clk);
        op_valid = 1; op = 3'b100; SrcA = 32'h12345678; SrcB = 32'd3;
        @(negedge clk);
        op = 3'b000;
        @(negedge clk);
        op_valid = 0; op = 3'b111;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        tests++;
        if ({done, hi, lo} !== {1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD}) begin
            fails++;
            $display("FAIL busy_ignore: done=%b hi=%h lo=%h, need 1 ffffffff fffffffd", done, hi, lo);
        end
        issue(3'b101, 32'h12345678, 32'd0);
        tests++;
        if ({done, hi, lo} !== {1'b1, 32'hFFFFFFFF, 32'h12345678}) begin
            fails++;
            $display("FAIL mtlo: done=%b hi=%h lo=%h, need 1 ffffffff 12345678", done, hi, lo);
        end
        issue(3'b110, 32'hDEAD, 32'hBEEF);
        tests++;
        if ({busy, done, hi, lo} !== {2'b00, 32'hFFFFFFFF, 32'h12345678}) begin
            fails++;
            $display("FAIL nop: busy=%b done=%b hi=%h lo=%h, need 0 0 ffffffff 12345678", busy, done, hi, lo);
        end
    endtask

    task automatic test_reset_mid;
        issue(3'b011, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        #2 reset = 1;
        #1;
        tests++;
        if ({busy, done, hi, lo} !== 66'd0) begin
            fails++;
            $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h, need all 0", busy, done, hi, lo);
        end
        #10 reset = 0;
        run_div("divu_100_7", 3'b011, 32'd100, 32'd7, 32'd2, 32'd14);
    endtask

`ifdef MULDIV_ABORT_EN
    task automatic test_abort;
        issue(3'b100, 32'hAAAA0000, 32'd0);
        issue(3'b101, 32'h00005555, 32'd0);
        issue(3'b010, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        abort = 1;
        @(negedge clk);
        abort = 0;
        tests++;
        if ({busy, done, hi, lo} !== {2'b00, 32'hAAAA0000, 32'h00005555}) begin
            fails++;
            $display("FAIL abort_mid: busy=%b done=%b hi=%h lo=%h, need 0 0 aaaa0000 00005555", busy, done, hi, lo);
        end
        issue(3'b010, 32'd100, 32'd7);
        repeat (32) @(negedge clk);
        abort = 1;
        @(negedge clk);
        abort = 0;
        tests++;
        if ({busy, done, hi, lo} !== {2'b00, 32'hAAAA0000, 32'h00005555}) begin
            fails++;
            $display("FAIL abort_fix: busy=%b done=%b hi=%h lo=%h, need 0 0 aaaa0000 00005555", busy, done, hi, lo);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL abort_late_done: done=%b, need 0", done);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_mul;
        test_div;
        test_div_zero;
        test_busy_ignore;
        test_reset_mid;
`ifdef MULDIV_ABORT_EN
        test_abort;
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
